alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue/writeback controller that drives the 8-bit ALU. It accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file. It issues a single-cycle alu_en to the ALU, captures the registered ALU result or compare flag one cycle later, and writes it back. It sits between instruction fetch/decode and the ALU.

Parameters:
DATA_W, 8, operand/result width; must equal the ALU width.
REG_AW, 2, register index width; the register file holds 2**REG_AW entries.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
inst_valid  in  1  instruction present.
inst_ready  out  1  controller can accept an instruction.
inst_funct  in  4  ALU function code.
inst_rd  in  REG_AW  destination register, also x-operand source.
inst_rs  in  REG_AW  y-operand source register.
inst_imm_en  in  1  1 = y comes from inst_imm instead of R[rs].
inst_imm  in  DATA_W  immediate y operand.
alu_en  out  1  ALU enable, one-cycle pulse.
alu_funct  out  4  function code to the ALU.
alu_x  out  DATA_W  x operand to the ALU.
alu_y  out  DATA_W  y operand to the ALU.
alu_result  in  DATA_W  registered ALU result.
alu_cmp  in  1  registered ALU equality flag.
cmp_flag  out  1  last captured compare result.
done  out  1  one-cycle pulse: an instruction retired.
illegal  out  1  one-cycle pulse: unsupported funct was consumed.
dbg_sel  in  REG_AW  register file read select.
dbg_data  out  DATA_W  R[dbg_sel], combinational.

Behaviour:
- Supported funct codes: 0101 add, 0100 sub, 1110 shl, 0111 shr, 0001 xor, 0011 and/or slot, 0110 cmp, 1010 sh. All other codes, including 0010, are illegal at this block.
- FSM states: IDLE, ISSUE, CAPTURE.
- IDLE:
  - inst_ready=1.
  - On a legal handshake (inst_valid & inst_ready): latch funct; latch x=R[inst_rd]; latch y = inst_imm_en ? inst_imm : R[inst_rs]; latch rd. Go to ISSUE.
  - On an illegal handshake: the instruction is consumed, nothing is latched, and the FSM stays in IDLE. illegal=1 in the next cycle, for that one cycle only.
- ISSUE:
  - inst_ready=0, alu_en=1.
  - alu_funct, alu_x and alu_y show the latched values.
  - Next state is CAPTURE unconditionally.
- CAPTURE:
  - inst_ready=0, alu_en=0.
  - At the closing edge: if funct==0110, cmp_flag<=alu_cmp and no register is written. Otherwise R[rd]<=alu_result and cmp_flag is unchanged.
  - Next state IDLE. done=1 in the following cycle, for exactly one cycle.
- Timing:
  - Latency from handshake edge to the register write edge is 2 cycles.
  - Peak throughput is 1 instruction per 3 cycles.
  - Operands are sampled at handshake time, so a dependent back-to-back instruction sees the written-back value.
- alu_funct, alu_x and alu_y hold their latched values outside ISSUE; only alu_en qualifies them.
- When rd==rs, both operands read the same pre-write value.
- Register write and dbg read of the same index in CAPTURE: dbg_data shows the old value until the edge.
- Reset (any state, including mid-ISSUE/CAPTURE):
  - state=IDLE.
  - Every register R[i]=0.
  - cmp_flag=0, done=0, illegal=0, alu_en=0.
  - alu_funct/alu_x/alu_y=0.
  - inst_ready=1 in the first cycle after reset.
  - An in-flight instruction is dropped with no writeback.
- Reset has priority over a simultaneous handshake.
- The ALU has no reset. A stale alu_result is never written, because capture only follows ISSUE.

Test Plan:
- Reset, then dbg_sel sweep -> all registers read 0; inst_ready=1; alu_en, done and illegal all 0.
- add imm: R0=0, funct=0101, rd=0, imm_en, imm=8'h05; then funct=0101, rd=0, imm=8'hFE -> R0=8'h05, then 8'h03 (wrap). alu_en high exactly one cycle; done 3 cycles after each handshake.
- shift/sh: R1=8'h81 via add; funct=1010, rd=1, imm=8'h0A (right by 2) -> R1=8'h20; then imm=8'h03 (left by 3) -> R1=8'h00; cmp_flag unchanged.
- cmp: R2=8'h20 and R3=8'h20 loaded; funct=0110, rd=2, rs=3 -> cmp_flag=1, R2 unchanged. Repeat with imm=8'h21 -> cmp_flag=0.
- illegal: funct=0010 with inst_valid held -> consumed in 1 cycle, illegal pulses once, alu_en never asserted, registers unchanged, next instruction accepted the following cycle.
- reset mid-op: assert reset during CAPTURE of funct=0101, rd=1, imm=8'h7F -> R1=0, done not asserted, FSM in IDLE, inst_ready=1 next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 8-bit ALU.
// It sends one instruction at a time to the ALU and writes the result back to a small register file.
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [3:0]        inst_funct,
    input  logic [REG_AW-1:0] inst_rd,
    input  logic [REG_AW-1:0] inst_rs,
    input  logic              inst_imm_en,
    input  logic [DATA_W-1:0] inst_imm,
    output logic              alu_en,
    output logic [3:0]        alu_funct,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cmp,
    output logic              cmp_flag,
    output logic              done,
    output logic              illegal,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG = 1 << REG_AW;
    localparam logic [3:0] F_CMP = 4'b0110;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rf [NREG];
    logic [REG_AW-1:0] rd_q;
    logic              legal;
    logic              hs;

    assign hs       = inst_valid & inst_ready;
    assign dbg_data = rf[dbg_sel];

    always_comb begin
        legal = 1'b0;
        case (inst_funct)
            4'b0101, 4'b0100,
            4'b1110, 4'b0111,
            4'b0001, 4'b0011,
            4'b0110, 4'b1010: legal = 1'b1;
            default:          legal = 1'b0;
        endcase
    end

    // Operands are read at handshake, so a following instruction sees the value written back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            inst_ready <= 1'b1;
            alu_en     <= 1'b0;
            alu_funct  <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            rd_q       <= '0;
            cmp_flag   <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (hs && legal) begin
                        alu_funct  <= inst_funct;
                        alu_x      <= rf[inst_rd];
                        alu_y      <= inst_imm_en ? inst_imm
                                                  : rf[inst_rs];
                        rd_q       <= inst_rd;
                        alu_en     <= 1'b1;
                        inst_ready <= 1'b0;
                        state      <= ISSUE;
                    end else if (hs) begin
                        illegal <= 1'b1;
                    end
                end
                ISSUE: begin
                    alu_en <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (alu_funct == F_CMP) begin
                        cmp_flag <= alu_cmp;
                    end else begin
                        rf[rd_q] <= alu_result;
                    end
                    done       <= 1'b1;
                    inst_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    alu_en     <= 1'b0;
                    inst_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, hand-written corner sequences,
// and random instructions checked against a register-file model.
`timescale 1ns/100ps
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       inst_valid;
    logic       inst_ready;
    logic [3:0] inst_funct;
    logic [1:0] inst_rd;
    logic [1:0] inst_rs;
    logic       inst_imm_en;
    logic [7:0] inst_imm;
    logic       alu_en;
    logic [3:0] alu_funct;
    logic [7:0] alu_x;
    logic [7:0] alu_y;
    logic [7:0] alu_result = 8'hA5;
    logic       alu_cmp = 1'b1;
    logic       cmp_flag;
    logic       done;
    logic       illegal;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] m [4];
    logic       mcmp;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(8), .REG_AW(2)) dut (
        .clk(clk), .reset(reset),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_funct(inst_funct), .inst_rd(inst_rd),
        .inst_rs(inst_rs), .inst_imm_en(inst_imm_en),
        .inst_imm(inst_imm), .alu_en(alu_en),
        .alu_funct(alu_funct), .alu_x(alu_x), .alu_y(alu_y),
        .alu_result(alu_result), .alu_cmp(alu_cmp),
        .cmp_flag(cmp_flag), .done(done), .illegal(illegal),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    function automatic logic [7:0] ref_alu(input logic [3:0] f,
                                           input logic [7:0] x,
                                           input logic [7:0] y);
        int s;
        s = int'(y[2:0]);
        case (f)
            4'b0101: return 8'((int'(x) + int'(y)) % 256);
            4'b0100: return 8'((int'(x) - int'(y) + 256) % 256);
            4'b1110: return 8'((int'(x) * (2 ** s)) % 256);
            4'b0111: return 8'(int'(x) / (2 ** s));
            4'b0001: return x ^ y;
            4'b0011: return x & y;
            4'b1010: return y[3] ? 8'(int'(x) / (2 ** s))
                                 : 8'((int'(x) * (2 ** s)) % 256);
            default: return 8'(int'(x) - int'(y));
        endcase
    endfunction

    // Stand-in for the registered, reset-less ALU.
    always @(posedge clk) begin
        if (alu_en) begin
            alu_result <= ref_alu(alu_funct, alu_x, alu_y);
            alu_cmp    <= (alu_x == alu_y);
        end
    end

    function automatic logic is_legal(input logic [3:0] f);
        return f inside {4'b0101, 4'b0100, 4'b1110, 4'b0111,
                         4'b0001, 4'b0011, 4'b0110, 4'b1010};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m[i] = 8'h00;
        mcmp = 1'b0;
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #0.5;
            chk(name, {24'h0, dbg_data}, {24'h0, m[i]});
        end
    endtask

    task automatic do_inst(input logic [3:0] f, input logic [1:0] rd,
                           input logic [1:0] rs, input logic ie,
                           input logic [7:0] imm);
        logic [7:0] x;
        logic [7:0] y;
        int n;
        n = 0;
        while (!inst_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", {31'h0, inst_ready}, 32'h1);
        x = m[rd];
        y = ie ? imm : m[rs];
        inst_valid = 1'b1;
        inst_funct = f;
        inst_rd = rd;
        inst_rs = rs;
        inst_imm_en = ie;
        inst_imm = imm;
        tick();
        inst_valid = 1'b0;
        chk("done_low_at_issue", {31'h0, done}, 32'h0);
        if (is_legal(f)) begin
            chk("alu_en_issue", {31'h0, alu_en}, 32'h1);
            chk("alu_funct", {28'h0, alu_funct}, {28'h0, f});
            chk("alu_x", {24'h0, alu_x}, {24'h0, x});
            chk("alu_y", {24'h0, alu_y}, {24'h0, y});
            chk("ready_busy", {31'h0, inst_ready}, 32'h0);
            chk("illegal_low", {31'h0, illegal}, 32'h0);
            tick();
            chk("alu_en_capture", {31'h0, alu_en}, 32'h0);
            chk("done_early", {31'h0, done}, 32'h0);
            chk("alu_x_hold", {24'h0, alu_x}, {24'h0, x});
            dbg_sel = rd;
            #0.5;
            chk("dbg_old_value", {24'h0, dbg_data}, {24'h0, m[rd]});
            if (f == 4'b0110) mcmp = (x == y);
            else m[rd] = ref_alu(f, x, y);
            tick();
            chk("done_pulse", {31'h0, done}, 32'h1);
            chk("ready_back", {31'h0, inst_ready}, 32'h1);
            chk("cmp_flag", {31'h0, cmp_flag}, {31'h0, mcmp});
            sweep("regfile");
        end else begin
            chk("illegal_pulse", {31'h0, illegal}, 32'h1);
            chk("alu_en_illegal", {31'h0, alu_en}, 32'h0);
            chk("ready_illegal", {31'h0, inst_ready}, 32'h1);
            tick();
            chk("illegal_once", {31'h0, illegal}, 32'h0);
            sweep("regfile_illegal");
        end
    endtask

    typedef struct {
        logic [3:0] f;
        logic [1:0] rd;
        logic [1:0] rs;
        logic       ie;
        logic [7:0] imm;
        logic [7:0] exp_reg;
        logic       exp_cmp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{4'b0101, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 1'b0};
        vecs[1]  = '{4'b0101, 2'd0, 2'd0, 1'b1, 8'hFE, 8'h03, 1'b0};
        vecs[2]  = '{4'b0101, 2'd1, 2'd0, 1'b1, 8'h81, 8'h81, 1'b0};
        vecs[3]  = '{4'b1010, 2'd1, 2'd0, 1'b1, 8'h0A, 8'h20, 1'b0};
        vecs[4]  = '{4'b1010, 2'd1, 2'd0, 1'b1, 8'h03, 8'h00, 1'b0};
        vecs[5]  = '{4'b0101, 2'd2, 2'd0, 1'b1, 8'h20, 8'h20, 1'b0};
        vecs[6]  = '{4'b0101, 2'd3, 2'd0, 1'b1, 8'h20, 8'h20, 1'b0};
        vecs[7]  = '{4'b0110, 2'd2, 2'd3, 1'b0, 8'h00, 8'h20, 1'b1};
        vecs[8]  = '{4'b0110, 2'd2, 2'd0, 1'b1, 8'h21, 8'h20, 1'b0};
        vecs[9]  = '{4'b0100, 2'd0, 2'd0, 1'b1, 8'h01, 8'h02, 1'b0};
        vecs[10] = '{4'b0001, 2'd0, 2'd0, 1'b0, 8'hFF, 8'h00, 1'b0};

        reset = 1'b1;
        inst_valid = 1'b0;
        inst_funct = 4'h0;
        inst_rd = 2'd0;
        inst_rs = 2'd0;
        inst_imm_en = 1'b0;
        inst_imm = 8'h00;
        dbg_sel = 2'd0;
        model_clear();
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", {31'h0, inst_ready}, 32'h1);
        chk("rst_alu_en", {31'h0, alu_en}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_illegal", {31'h0, illegal}, 32'h0);
        chk("rst_cmp", {31'h0, cmp_flag}, 32'h0);
        chk("rst_alu_x", {24'h0, alu_x}, 32'h0);
        chk("rst_alu_y", {24'h0, alu_y}, 32'h0);
        chk("rst_alu_funct", {28'h0, alu_funct}, 32'h0);
        sweep("rst_regfile");

        foreach (vecs[i]) begin
            do_inst(vecs[i].f, vecs[i].rd, vecs[i].rs,
                    vecs[i].ie, vecs[i].imm);
            dbg_sel = vecs[i].rd;
            #0.5;
            chk($sformatf("vec%0d_reg", i), {24'h0, dbg_data},
                {24'h0, vecs[i].exp_reg});
            chk($sformatf("vec%0d_cmp", i), {31'h0, cmp_flag},
                {31'h0, vecs[i].exp_cmp});
        end

        // Illegal code with valid held, then a legal one right behind it.
        inst_valid = 1'b1;
        inst_funct = 4'b0010;
        inst_rd = 2'd1;
        inst_imm_en = 1'b1;
        inst_imm = 8'h11;
        tick();
        chk("ill_seq_pulse", {31'h0, illegal}, 32'h1);
        chk("ill_seq_no_alu", {31'h0, alu_en}, 32'h0);
        chk("ill_seq_ready", {31'h0, inst_ready}, 32'h1);
        inst_funct = 4'b0101;
        tick();
        inst_valid = 1'b0;
        chk("ill_seq_next_acc", {31'h0, alu_en}, 32'h1);
        chk("ill_seq_one_pulse", {31'h0, illegal}, 32'h0);
        chk("ill_seq_y", {24'h0, alu_y}, 32'h11);
        m[1] = ref_alu(4'b0101, m[1], 8'h11);
        tick();
        tick();
        chk("ill_seq_done", {31'h0, done}, 32'h1);
        sweep("ill_seq_regs");

        // Reset during CAPTURE drops the write.
        inst_valid = 1'b1;
        inst_funct = 4'b0101;
        inst_rd = 2'd1;
        inst_imm_en = 1'b1;
        inst_imm = 8'h7F;
        tick();
        inst_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        chk("midrst_done", {31'h0, done}, 32'h0);
        chk("midrst_ready", {31'h0, inst_ready}, 32'h1);
        chk("midrst_alu_en", {31'h0, alu_en}, 32'h0);
        chk("midrst_alu_x", {24'h0, alu_x}, 32'h0);
        sweep("midrst_regs");
        tick();
        chk("midrst_no_done", {31'h0, done}, 32'h0);
        sweep("midrst_regs2");

        // Reset wins over a simultaneous handshake.
        inst_valid = 1'b1;
        inst_funct = 4'b0101;
        inst_rd = 2'd2;
        inst_imm = 8'h33;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        inst_valid = 1'b0;
        chk("rstprio_alu_en", {31'h0, alu_en}, 32'h0);
        chk("rstprio_ready", {31'h0, inst_ready}, 32'h1);
        tick();
        tick();
        chk("rstprio_done", {31'h0, done}, 32'h0);
        sweep("rstprio_regs");

        for (int k = 0; k < 60; k++) begin
            do_inst(4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
